// File: rtl/encoder_acq_sched.sv
`default_nettype none
// ============================================================================
// Module : encoder_acq_sched
// Multi-channel acquisition scheduler: periodic request tick, ascending-order
// engine requests with per-channel timeout, angle capture and sticky status.
// Option : define ENCODER_ACQ_ERRCNT_EN to build the saturating error counter;
//          otherwise err_cnt is tied to zero.
// Rev    : 1.0  initial release
// ============================================================================
module encoder_acq_sched #(
    parameter int N_CH    = 4,
    parameter int DW      = 32,
    parameter int PER_W   = 16,
    parameter int TMO_CYC = 20000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PER_W-1:0]     period,
    input  logic [N_CH-1:0]      ch_en,
    input  logic                 sts_clr,
    input  logic [N_CH-1:0]      done,
    input  logic [N_CH-1:0]      eng_err,
    input  logic [N_CH*DW-1:0]   eng_data,
    output logic [N_CH-1:0]      req,
    output logic [N_CH*DW-1:0]   data_out,
    output logic [N_CH-1:0]      data_vld,
    output logic [N_CH-1:0]      tmo_flag,
    output logic [N_CH-1:0]      crc_flag,
    output logic                 overrun,
    output logic                 busy,
    output logic [15:0]          frame_id,
    output logic [15:0]          err_cnt
);

    localparam int c_IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_TW = $clog2(TMO_CYC);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TMO_CYC - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_NEXT  = 2'd3;

    logic [1:0]           r_state;
    logic [c_IW-1:0]      r_idx;
    logic [PER_W-1:0]     r_timer;
    logic [c_TW-1:0]      r_tmo;
    logic [N_CH-1:0]      r_req;
    logic [N_CH*DW-1:0]   r_data_out;
    logic [N_CH-1:0]      r_data_vld;
    logic [N_CH-1:0]      r_tmo_flag;
    logic [N_CH-1:0]      r_crc_flag;
    logic                 r_overrun;
    logic [15:0]          r_frame_id;

    logic                 w_tick;
    logic                 w_first_vld;
    logic [c_IW-1:0]      w_first_idx;
    logic                 w_next_vld;
    logic [c_IW-1:0]      w_next_idx;
    logic [N_CH-1:0]      w_idx_oh;
    logic [N_CH-1:0]      w_first_oh;
    logic [N_CH-1:0]      w_next_oh;
    logic                 w_in_wait;
    logic                 w_done_cur;
    logic                 w_err_cur;
    logic                 w_hit;
    logic                 w_tmo_hit;
    logic                 w_cap;
    logic [N_CH-1:0]      w_crc_set;
    logic [N_CH-1:0]      w_tmo_set;

    assign w_tick = (period != '0) && (r_timer >= period);

    // Descending scan so the lowest qualifying channel is the one left standing.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_idx = '0;
        w_next_vld  = 1'b0;
        w_next_idx  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                w_first_vld = 1'b1;
                w_first_idx = c_IW'(i);
            end
            if (ch_en[i] && (c_IW'(i) > r_idx)) begin
                w_next_vld = 1'b1;
                w_next_idx = c_IW'(i);
            end
        end
        w_idx_oh   = '0;
        w_first_oh = '0;
        w_next_oh  = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_idx_oh[i]   = (r_idx == c_IW'(i));
            w_first_oh[i] = (w_first_idx == c_IW'(i));
            w_next_oh[i]  = (w_next_idx == c_IW'(i));
        end
    end

    always_comb begin
        w_in_wait  = (r_state == c_WAIT);
        w_done_cur = |(done & w_idx_oh);
        w_err_cur  = |(eng_err & w_idx_oh);
        w_hit      = w_in_wait && w_done_cur;
        w_tmo_hit  = w_in_wait && !w_done_cur && (r_tmo == c_TMO_LAST);
        w_cap      = w_hit && !w_err_cur;
        w_crc_set  = (w_hit && w_err_cur) ? w_idx_oh : '0;
        w_tmo_set  = w_tmo_hit ? w_idx_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_idx      <= '0;
            r_timer    <= '0;
            r_tmo      <= '0;
            r_req      <= '0;
            r_data_out <= '0;
            r_data_vld <= '0;
            r_tmo_flag <= '0;
            r_crc_flag <= '0;
            r_overrun  <= 1'b0;
            r_frame_id <= '0;
        end else begin
            r_timer    <= w_tick ? '0 : r_timer + PER_W'(1);
            r_req      <= '0;
            r_data_vld <= w_cap ? w_idx_oh : '0;

            // A set in the same cycle as sts_clr survives the clear.
            r_tmo_flag <= (sts_clr ? '0 : r_tmo_flag) | w_tmo_set;
            r_crc_flag <= (sts_clr ? '0 : r_crc_flag) | w_crc_set;
            r_overrun  <= (sts_clr ? 1'b0 : r_overrun) | (w_tick && (r_state != c_IDLE));

            for (int i = 0; i < N_CH; i++) begin
                if (w_cap && w_idx_oh[i]) begin
                    r_data_out[i*DW +: DW] <= eng_data[i*DW +: DW];
                end
            end

            case (r_state)
                c_IDLE: begin
                    if (w_tick && w_first_vld) begin
                        r_idx      <= w_first_idx;
                        r_req      <= w_first_oh;
                        r_frame_id <= r_frame_id + 16'd1;
                        r_state    <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (w_hit || w_tmo_hit) begin
                        r_state <= c_NEXT;
                    end else begin
                        r_tmo <= r_tmo + c_TW'(1);
                    end
                end
                default: begin
                    if (w_next_vld) begin
                        r_idx   <= w_next_idx;
                        r_req   <= w_next_oh;
                        r_state <= c_ISSUE;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef ENCODER_ACQ_ERRCNT_EN
    logic        w_err_inc;
    logic [15:0] w_err_base;
    logic [15:0] r_err_cnt;

    assign w_err_inc  = (w_hit && w_err_cur) || w_tmo_hit;
    assign w_err_base = sts_clr ? 16'h0000 : r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err_inc) begin
            r_err_cnt <= (w_err_base == 16'hFFFF) ? 16'hFFFF : w_err_base + 16'd1;
        end else begin
            r_err_cnt <= w_err_base;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'h0000;
`endif

    assign req      = r_req;
    assign data_out = r_data_out;
    assign data_vld = r_data_vld;
    assign tmo_flag = r_tmo_flag;
    assign crc_flag = r_crc_flag;
    assign overrun  = r_overrun;
    assign busy     = (r_state != c_IDLE);
    assign frame_id = r_frame_id;

endmodule
`default_nettype wire

// File: tb/tb_encoder_acq_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_encoder_acq_sched
// Scoreboard bench for encoder_acq_sched with a behavioural engine model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_encoder_acq_sched;

    localparam int N_CH    = 4;
    localparam int DW      = 32;
    localparam int PER_W   = 16;
    localparam int TMO_CYC = 50;
`ifdef ENCODER_ACQ_ERRCNT_EN
    localparam logic [15:0] c_ERR_ONE = 16'd1;
`else
    localparam logic [15:0] c_ERR_ONE = 16'd0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [PER_W-1:0]     period = '0;
    logic [N_CH-1:0]      ch_en = '0;
    logic                 sts_clr = 1'b0;
    logic [N_CH-1:0]      done;
    logic [N_CH-1:0]      eng_err;
    logic [N_CH*DW-1:0]   eng_data;
    logic [N_CH-1:0]      req;
    logic [N_CH*DW-1:0]   data_out;
    logic [N_CH-1:0]      data_vld;
    logic [N_CH-1:0]      tmo_flag;
    logic [N_CH-1:0]      crc_flag;
    logic                 overrun;
    logic                 busy;
    logic [15:0]          frame_id;
    logic [15:0]          err_cnt;

    encoder_acq_sched #(
        .N_CH(N_CH), .DW(DW), .PER_W(PER_W), .TMO_CYC(TMO_CYC)
    ) u_dut (
        .clk(clk), .rst(rst), .period(period), .ch_en(ch_en), .sts_clr(sts_clr),
        .done(done), .eng_err(eng_err), .eng_data(eng_data), .req(req),
        .data_out(data_out), .data_vld(data_vld), .tmo_flag(tmo_flag),
        .crc_flag(crc_flag), .overrun(overrun), .busy(busy),
        .frame_id(frame_id), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;
    int t_base = 0;

    typedef struct {
        int              ch;
        int              cyc;
        logic [DW-1:0]   data;
    } ev_t;
    ev_t q_req[$];
    ev_t q_vld[$];

    // engine model configuration
    int              lat     [N_CH];
    logic            err_cfg [N_CH];
    logic [DW-1:0]   dval    [N_CH];
    int              stray_at[N_CH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        q_req.delete();
        q_vld.delete();
        rst = 1'b1;
        repeat (n) @(negedge clk);
        t_base = cyc;
        rst = 1'b0;
    endtask

    // req expected at rc; a capture follows lt+1 cycles later when lt > 0
    task automatic push_chan(input int ch, input int rc, input int lt, input logic [DW-1:0] d);
        ev_t e;
        e.ch = ch; e.cyc = rc; e.data = '0;
        q_req.push_back(e);
        if (lt > 0) begin
            e.cyc  = rc + lt + 1;
            e.data = d;
            q_vld.push_back(e);
        end
    endtask

    task automatic sb_done(input string tag);
        check({tag, "_req_left"}, q_req.size(), 0);
        check({tag, "_vld_left"}, q_vld.size(), 0);
    endtask

    task automatic check_slice(input string tag, input int ch, input logic [DW-1:0] exp);
        check(tag, data_out[ch*DW +: DW], exp);
    endtask

    // engine model: done lat cycles after its req, plus optional stray pulses
    initial begin : engine
        int cnt[N_CH];
        done = '0; eng_err = '0; eng_data = '0;
        for (int i = 0; i < N_CH; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            done = '0;
            eng_err = '0;
            for (int i = 0; i < N_CH; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        done[i] = 1'b1;
                        eng_err[i] = err_cfg[i];
                        eng_data[i*DW +: DW] = dval[i];
                    end
                end
                if (req[i] && lat[i] > 0) cnt[i] = lat[i];
                if (cyc == stray_at[i]) begin
                    done[i] = 1'b1;
                    eng_data[i*DW +: DW] = 32'hDEAD_0000 | DW'(i);
                end
            end
        end
    end

    // output monitor, sampled 2 time units after the rising edge
    initial begin : monitor
        ev_t e;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N_CH; i++) begin
                if (req[i]) begin
                    if (q_req.size() == 0) check("req_unexpected", i, 99);
                    else begin
                        e = q_req.pop_front();
                        check("req_ch", i, e.ch);
                        check("req_cyc", cyc, e.cyc);
                    end
                end
                if (data_vld[i]) begin
                    if (q_vld.size() == 0) check("vld_unexpected", i, 99);
                    else begin
                        e = q_vld.pop_front();
                        check("vld_ch", i, e.ch);
                        check("vld_cyc", cyc, e.cyc);
                        check("vld_data", data_out[i*DW +: DW], e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        for (int i = 0; i < N_CH; i++) begin
            lat[i] = 5; err_cfg[i] = 1'b0; dval[i] = 32'h100 + DW'(i); stray_at[i] = -1;
        end
        @(negedge clk);

        // full sweeps, all channels
        period = 16'd99; ch_en = 4'b1111;
        do_reset(3);
        check("rst_req", req, 0);
        check("rst_frame", frame_id, 0);
        check("rst_busy", busy, 0);
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < N_CH; i++)
                push_chan(i, t_base + 100 + 100*s + 7*i, 5, 32'h100 + DW'(i));
        wait_to(t_base + 99);
        check("frame_before_tick", frame_id, 0);
        check("busy_before_tick", busy, 0);
        wait_to(t_base + 100);
        check("frame_first", frame_id, 1);
        check("busy_sweep", busy, 1);
        wait_to(t_base + 327);
        check("busy_last_next", busy, 1);
        wait_to(t_base + 328);
        check("busy_idle", busy, 0);
        check("frame_three", frame_id, 3);
        for (int i = 0; i < N_CH; i++) check_slice("s1_slice", i, 32'h100 + DW'(i));
        sb_done("s1");

        // sparse enable mask
        ch_en = 4'b1010;
        do_reset(2);
        push_chan(1, t_base + 100, 5, 32'h101);
        push_chan(3, t_base + 107, 5, 32'h103);
        wait_to(t_base + 115);
        check_slice("s2_slice0", 0, 32'h0);
        check_slice("s2_slice1", 1, 32'h101);
        check_slice("s2_slice2", 2, 32'h0);
        check_slice("s2_slice3", 3, 32'h103);
        check("s2_frame", frame_id, 1);
        sb_done("s2");

        // channel 2 silent -> timeout
        ch_en = 4'b1111; lat[2] = 0;
        do_reset(2);
        push_chan(0, t_base + 100, 5, 32'h100);
        push_chan(1, t_base + 107, 5, 32'h101);
        push_chan(2, t_base + 114, 0, 32'h0);
        push_chan(3, t_base + 166, 5, 32'h103);
        wait_to(t_base + 164);
        check("tmo_early", tmo_flag, 4'b0000);
        wait_to(t_base + 165);
        check("tmo_set", tmo_flag, 4'b0100);
        wait_to(t_base + 176);
        check("tmo_sticky", tmo_flag, 4'b0100);
        check("tmo_errcnt", err_cnt, c_ERR_ONE);
        check("tmo_crc", crc_flag, 4'b0000);
        sts_clr = 1'b1;
        wait_to(t_base + 177);
        sts_clr = 1'b0;
        check("clr_tmo", tmo_flag, 4'b0000);
        check("clr_errcnt", err_cnt, 0);
        sb_done("s3");
        lat[2] = 5;

        // engine error on channel 1 in the second sweep
        do_reset(2);
        for (int i = 0; i < N_CH; i++) push_chan(i, t_base + 100 + 7*i, 5, 32'h100 + DW'(i));
        push_chan(0, t_base + 200, 5, 32'h200);
        push_chan(1, t_base + 207, 0, 32'h0);
        push_chan(2, t_base + 214, 5, 32'h202);
        push_chan(3, t_base + 221, 5, 32'h203);
        wait_to(t_base + 150);
        err_cfg[1] = 1'b1;
        for (int i = 0; i < N_CH; i++) dval[i] = 32'h200 + DW'(i);
        wait_to(t_base + 212);
        check("crc_early", crc_flag, 4'b0000);
        wait_to(t_base + 213);
        check("crc_set", crc_flag, 4'b0010);
        wait_to(t_base + 230);
        check_slice("crc_slice1_kept", 1, 32'h101);
        check_slice("crc_slice0_new", 0, 32'h200);
        check("crc_errcnt", err_cnt, c_ERR_ONE);
        check("crc_tmo", tmo_flag, 4'b0000);
        sb_done("s4");
        err_cfg[1] = 1'b0;
        for (int i = 0; i < N_CH; i++) dval[i] = 32'h100 + DW'(i);

        // short period vs slow engine: overrun, stray dones ignored
        period = 16'd5; ch_en = 4'b0001; lat[0] = 20;
        do_reset(2);
        stray_at[0] = t_base + 3;
        stray_at[2] = t_base + 15;
        push_chan(0, t_base + 6, 20, 32'h100);
        push_chan(0, t_base + 30, 20, 32'h100);
        wait_to(t_base + 11);
        check("ovr_early", overrun, 0);
        wait_to(t_base + 12);
        check("ovr_set", overrun, 1);
        wait_to(t_base + 52);
        period = 16'd0;
        check("ovr_busy_idle", busy, 0);
        wait_to(t_base + 70);
        check("ovr_frame", frame_id, 2);
        check("ovr_sticky", overrun, 1);
        check_slice("ovr_slice0", 0, 32'h100);
        check_slice("ovr_slice2", 2, 32'h0);
        sb_done("s5");
        for (int i = 0; i < N_CH; i++) stray_at[i] = -1;
        lat[0] = 5;

        // reset while waiting on channel 1
        period = 16'd99; ch_en = 4'b1111;
        do_reset(2);
        push_chan(0, t_base + 100, 5, 32'h100);
        push_chan(1, t_base + 107, 0, 32'h0);
        wait_to(t_base + 109);
        check("mid_busy", busy, 1);
        sb_done("s6a");
        do_reset(1);
        check("mr_busy", busy, 0);
        check("mr_req", req, 0);
        check("mr_data", data_out[63:0], 0);
        check("mr_data_hi", data_out[127:64], 0);
        check("mr_vld", data_vld, 0);
        check("mr_flags", {tmo_flag, crc_flag, overrun}, 0);
        check("mr_frame", frame_id, 0);
        check("mr_errcnt", err_cnt, 0);
        for (int i = 0; i < N_CH; i++) push_chan(i, t_base + 100 + 7*i, 5, 32'h100 + DW'(i));
        wait_to(t_base + 130);
        check("mr_frame_after", frame_id, 1);
        sb_done("s6b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
